simd2x_bicubic_mac: RTL and testbench
=====================================

# simd2x_bicubic_mac

Two-channel SIMD multiply-accumulate stage that computes one 4-tap bicubic interpolation sum per channel. Both channels share one coefficient per tap, and the taps arrive serially. The block sits directly upstream of the SIMD 2x rounding stage: its wide signed accumulator outputs become the rounding stage's `rin_ch0` / `rin_ch1` inputs, which are later right-shifted by the coefficient fraction width.

## Interface
Parameters:
- `PIXEL_WIDTH`, default 8: unsigned pixel sample width.
- `COEF_WIDTH`, default 10: signed coefficient width, two's complement, 8 fractional bits.
- `TAPS`, default 4: taps per output sum; must be ≥ 2.
- `ACC_WIDTH`, default 48: signed accumulator/output width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `sclr` in 1: synchronous abort/clear.
- `s_valid` in 1: input tap beat valid.
- `s_ready` out 1: input tap beat accepted when high together with `s_valid`.
- `s_pix_ch0` in PIXEL_WIDTH: channel 0 pixel for this tap.
- `s_pix_ch1` in PIXEL_WIDTH: channel 1 pixel for this tap.
- `s_coef` in COEF_WIDTH: shared signed coefficient for this tap.
- `m_valid` out 1: output sum valid.
- `m_ready` in 1: downstream accepts the sum.
- `m_acc_ch0` out ACC_WIDTH: signed channel 0 sum.
- `m_acc_ch1` out ACC_WIDTH: signed channel 1 sum.
- `tap_idx` out clog2(TAPS): index of the next tap expected.

## Operation
- **Product:** per channel, `$signed({1'b0, pix}) * $signed(coef)`.
  - Product width is PIXEL_WIDTH+1+COEF_WIDTH.
  - Sign-extend the product to ACC_WIDTH before adding.
  - No saturation; ACC_WIDTH ≥ product width + clog2(TAPS) is guaranteed by the parameter check (elaboration `$error` otherwise).
- **Tap counter `tap_idx`** (0..TAPS-1) advances on every accepted beat and wraps to 0 after TAPS-1.
- **Accumulator per channel:**
  - Tap 0: `acc <= product` (implicit clear).
  - Taps 1..TAPS-2: `acc <= acc + product`.
  - Tap TAPS-1: the output register loads `acc + product`; the accumulator is don't-care afterwards.
- **Output register handshake:**
  - `m_valid` is set on acceptance of tap TAPS-1.
  - `m_valid` clears on `m_valid && m_ready` unless a new final tap is accepted in the same cycle, in which case it stays set and the data is replaced.
  - `m_acc_*` are stable while `m_valid && !m_ready`.
- **`s_ready`** = `!(tap_idx == TAPS-1 && m_valid && !m_ready)`.
  - Taps 0..TAPS-2 of the next group are always accepted, which overlaps accumulation with downstream stall.
  - Only the final tap stalls.
- **States:** ACCUM (`tap_idx` 0..TAPS-1, `m_valid` = 0) and ACCUM+HOLD (`m_valid` = 1). There is no separate FSM beyond `tap_idx` and `m_valid`.
- **`sclr`** has priority over every other input in that cycle:
  - `tap_idx` <= 0, accumulators <= 0, `m_valid` <= 0.
  - `m_acc_*` <= 0.
  - The beat on the `sclr` cycle is dropped, but `s_ready` stays per formula.
- **Reset values:** `m_valid` = 0, `m_acc_ch0` = 0, `m_acc_ch1` = 0, `tap_idx` = 0, `s_ready` = 1.

## Timing
- Latency: the final tap accepted at edge N gives `m_valid` = 1 and data visible after edge N, i.e. in cycle N+1.
- Throughput: one sum per TAPS cycles when `m_ready` = 1; no bubbles between groups.
- Simultaneous final-tap accept and output consume: the new sum replaces the old in one edge, and `m_valid` stays 1.
- `aresetn` mid-group discards the partial sum; the first beat after release is tap 0.
- `s_ready` is combinational from `m_ready`; `m_ready` must not depend combinationally on `s_valid`.

## Structure
- Shared package `simd2x_pkg` holds:
  - `PIXEL_WIDTH`, `COEF_WIDTH`, `COEF_FRAC` = 8, `ACC_WIDTH`, and `TAPS` defaults.
  - Typedefs `pix_t`, `coef_t`, `acc_t`.
  - The same `COEF_FRAC` is used as the rounding stage's RSHIFT_RANGE.
- One sub-module, `simd2x_tap_mul`: purely combinational; takes two pixels and one coefficient and returns two sign-extended `acc_t` products. It is instantiated once and is the intended DSP packing point.

## Test plan
- **Half-phase kernel:** coefs [-16, 144, 144, -16], ch0 pixels [100, 100, 100, 100], ch1 pixels [0, 255, 255, 0], `m_ready` = 1 → `m_acc_ch0` = 25600, `m_acc_ch1` = 73440, `m_valid` high one cycle after the 4th beat.
- **Extreme negative:** coef -512 on all taps, pixels 255/0 → ch0 = -522240, ch1 = 0, with no wrap in 48 bits.
- **Backpressure:**
  - Hold `m_ready` = 0 after the first sum.
  - Feed the next group: taps 0..2 accepted, `s_ready` = 0 at tap 3, first sum held stable.
  - Release `m_ready` → tap 3 accepted in the same cycle, and the second sum appears next cycle.
- **Back-to-back streaming:** 8 groups with `s_valid` constantly high and `m_ready` = 1 → 8 consecutive correct sums, one every 4 cycles, `tap_idx` wrapping 3→0.
- **Mid-group `sclr`:** assert `sclr` after tap 2 with `m_valid` = 1 → `m_valid` = 0, `tap_idx` = 0, and the next 4 beats form a correct independent sum.
- **Async reset:** `aresetn` pulse between clock edges mid-group → all outputs 0 immediately, `s_ready` = 1, and the following group is correct.

Source files
------------

// File: rtl/simd2x_pkg.sv
// Shared defaults and payload types for the SIMD 2x bicubic datapath.
// COEF_FRAC doubles as the downstream rounding stage's RSHIFT_RANGE.
package simd2x_pkg;

    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned COEF_WIDTH  = 10;
    localparam int unsigned COEF_FRAC   = 8;
    localparam int unsigned ACC_WIDTH   = 48;
    localparam int unsigned TAPS        = 4;

    typedef logic        [PIXEL_WIDTH-1:0] pix_t;
    typedef logic signed [COEF_WIDTH-1:0]  coef_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;

endpackage

// File: rtl/simd2x_bicubic_mac_if.sv
// Tap-beat input stream and sum output stream of the bicubic MAC stage.
interface simd2x_bicubic_mac_if #(
    parameter int unsigned PIXEL_WIDTH = simd2x_pkg::PIXEL_WIDTH,
    parameter int unsigned COEF_WIDTH  = simd2x_pkg::COEF_WIDTH,
    parameter int unsigned ACC_WIDTH   = simd2x_pkg::ACC_WIDTH,
    parameter int unsigned TAPS        = simd2x_pkg::TAPS
);

    localparam int unsigned TAP_W = $clog2(TAPS);

    logic                          s_valid;
    logic                          s_ready;
    logic        [PIXEL_WIDTH-1:0] s_pix_ch0;
    logic        [PIXEL_WIDTH-1:0] s_pix_ch1;
    logic signed [COEF_WIDTH-1:0]  s_coef;
    logic                          m_valid;
    logic                          m_ready;
    logic signed [ACC_WIDTH-1:0]   m_acc_ch0;
    logic signed [ACC_WIDTH-1:0]   m_acc_ch1;
    logic        [TAP_W-1:0]       tap_idx;

    // MAC side: sinks tap beats, sources sums
    modport slave (
        input  s_valid, s_pix_ch0, s_pix_ch1, s_coef, m_ready,
        output s_ready, m_valid, m_acc_ch0, m_acc_ch1, tap_idx
    );

    // Environment side: sources tap beats, sinks sums
    modport master (
        output s_valid, s_pix_ch0, s_pix_ch1, s_coef, m_ready,
        input  s_ready, m_valid, m_acc_ch0, m_acc_ch1, tap_idx
    );

endinterface

// File: rtl/simd2x_tap_mul.sv
// Dual-channel pixel x shared-coefficient multiplier, sign-extended to the
// accumulator width. Purely combinational; the intended DSP packing point.
module simd2x_tap_mul #(
    parameter int unsigned PIXEL_WIDTH = simd2x_pkg::PIXEL_WIDTH,
    parameter int unsigned COEF_WIDTH  = simd2x_pkg::COEF_WIDTH,
    parameter int unsigned ACC_WIDTH   = simd2x_pkg::ACC_WIDTH
) (
    input  logic        [PIXEL_WIDTH-1:0] pix_ch0,
    input  logic        [PIXEL_WIDTH-1:0] pix_ch1,
    input  logic signed [COEF_WIDTH-1:0]  coef,
    output logic signed [ACC_WIDTH-1:0]   prod_ch0_c,
    output logic signed [ACC_WIDTH-1:0]   prod_ch1_c
);

    localparam int unsigned PROD_W = PIXEL_WIDTH + 1 + COEF_WIDTH;

    logic signed [PROD_W-1:0] mul_ch0;
    logic signed [PROD_W-1:0] mul_ch1;

    // Pixels are unsigned: a zero MSB keeps them positive in the signed multiply
    assign mul_ch0 = PROD_W'($signed({1'b0, pix_ch0})) * PROD_W'(coef);
    assign mul_ch1 = PROD_W'($signed({1'b0, pix_ch1})) * PROD_W'(coef);

    assign prod_ch0_c = ACC_WIDTH'(mul_ch0);
    assign prod_ch1_c = ACC_WIDTH'(mul_ch1);

endmodule

// File: rtl/simd2x_bicubic_mac.sv
// Two-channel serial-tap bicubic MAC: accumulates TAPS products per channel and
// presents each sum through a one-deep output register with valid/ready.
module simd2x_bicubic_mac #(
    parameter int unsigned PIXEL_WIDTH = simd2x_pkg::PIXEL_WIDTH,
    parameter int unsigned COEF_WIDTH  = simd2x_pkg::COEF_WIDTH,
    parameter int unsigned TAPS        = simd2x_pkg::TAPS,
    parameter int unsigned ACC_WIDTH   = simd2x_pkg::ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  sclr,
    simd2x_bicubic_mac_if.slave   bus
);

    localparam int unsigned TAP_W  = $clog2(TAPS);
    localparam int unsigned PROD_W = PIXEL_WIDTH + 1 + COEF_WIDTH;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    if (TAPS < 2) begin : g_bad_taps
        $error("simd2x_bicubic_mac: TAPS must be at least 2");
    end
    if (ACC_WIDTH < PROD_W + TAP_W) begin : g_bad_acc
        $error("simd2x_bicubic_mac: ACC_WIDTH too narrow for TAPS products");
    end

    logic        [TAP_W-1:0]     tap_q,   tap_d;
    logic signed [ACC_WIDTH-1:0] acc0_q,  acc0_d;
    logic signed [ACC_WIDTH-1:0] acc1_q,  acc1_d;
    logic signed [ACC_WIDTH-1:0] macc0_q, macc0_d;
    logic signed [ACC_WIDTH-1:0] macc1_q, macc1_d;
    logic                        mval_q,  mval_d;

    logic signed [ACC_WIDTH-1:0] prod0_c;
    logic signed [ACC_WIDTH-1:0] prod1_c;
    logic                        last_c;
    logic                        ready_c;
    logic                        accept_c;

    simd2x_tap_mul #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .COEF_WIDTH  (COEF_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_tap_mul (
        .pix_ch0    (bus.s_pix_ch0),
        .pix_ch1    (bus.s_pix_ch1),
        .coef       (bus.s_coef),
        .prod_ch0_c (prod0_c),
        .prod_ch1_c (prod1_c)
    );

    // Only the final tap can stall: it needs the output register free
    assign last_c   = (tap_q == LAST_TAP);
    assign ready_c  = !(last_c && mval_q && !bus.m_ready);
    assign accept_c = bus.s_valid && ready_c;

    assign bus.s_ready   = ready_c;
    assign bus.m_valid   = mval_q;
    assign bus.m_acc_ch0 = macc0_q;
    assign bus.m_acc_ch1 = macc1_q;
    assign bus.tap_idx   = tap_q;

    // State registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tap_q   <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            macc0_q <= '0;
            macc1_q <= '0;
            mval_q  <= 1'b0;
        end else begin
            tap_q   <= tap_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            macc0_q <= macc0_d;
            macc1_q <= macc1_d;
            mval_q  <= mval_d;
        end
    end

    // Next-state: sclr wins; otherwise consume, then accumulate or publish
    always_comb begin
        tap_d   = tap_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        macc0_d = macc0_q;
        macc1_d = macc1_q;
        mval_d  = mval_q;

        if (sclr) begin
            tap_d   = '0;
            acc0_d  = '0;
            acc1_d  = '0;
            macc0_d = '0;
            macc1_d = '0;
            mval_d  = 1'b0;
        end else begin
            if (mval_q && bus.m_ready) begin
                mval_d = 1'b0;
            end
            if (accept_c) begin
                if (last_c) begin
                    tap_d   = '0;
                    macc0_d = acc0_q + prod0_c;
                    macc1_d = acc1_q + prod1_c;
                    mval_d  = 1'b1;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                    if (tap_q == '0) begin
                        acc0_d = prod0_c;
                        acc1_d = prod1_c;
                    end else begin
                        acc0_d = acc0_q + prod0_c;
                        acc1_d = acc1_q + prod1_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_simd2x_bicubic_mac.sv
// Directed bench for simd2x_bicubic_mac: a group-level sum model checked every
// cycle on the falling edge, plus literal expectations for the named scenarios.
module tb_simd2x_bicubic_mac;
    import simd2x_pkg::*;

    logic clk = 1'b0;
    logic aresetn;
    logic sclr;

    always #5 clk = ~clk;

    simd2x_bicubic_mac_if bus ();

    simd2x_bicubic_mac dut (
        .clk     (clk),
        .aresetn (aresetn),
        .sclr    (sclr),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int n_sums = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Group-level model: taps gathered into a running dot product per channel
    int     grp_n;
    longint grp0, grp1;
    bit     out_v;
    longint out0, out1;

    always @(negedge clk) begin
        bit exp_ready;
        if (!aresetn) begin
            grp_n = 0; grp0 = 0; grp1 = 0;
            out_v = 1'b0; out0 = 0; out1 = 0;
        end else begin
            check("tap_idx", longint'(bus.tap_idx), longint'(grp_n));
            check("m_valid", longint'(bus.m_valid), longint'(out_v));
            if (out_v) begin
                check("m_acc_ch0", longint'(bus.m_acc_ch0), out0);
                check("m_acc_ch1", longint'(bus.m_acc_ch1), out1);
            end
            exp_ready = !(grp_n == TAPS - 1 && out_v && !bus.m_ready);
            check("s_ready", longint'(bus.s_ready), longint'(exp_ready));
            if (sclr) begin
                grp_n = 0; grp0 = 0; grp1 = 0;
                out_v = 1'b0; out0 = 0; out1 = 0;
            end else begin
                if (out_v && bus.m_ready) begin
                    out_v = 1'b0;
                    n_sums++;
                end
                if (bus.s_valid && exp_ready) begin
                    grp0 += longint'(bus.s_pix_ch0) * longint'(bus.s_coef);
                    grp1 += longint'(bus.s_pix_ch1) * longint'(bus.s_coef);
                    grp_n++;
                    if (grp_n == TAPS) begin
                        out0 = grp0; out1 = grp1; out_v = 1'b1;
                        grp_n = 0; grp0 = 0; grp1 = 0;
                    end
                end
            end
        end
    end

    // One beat: present it and wait (bounded) for the accepting edge
    task automatic drive(input int p0, input int p1, input int c);
        bit ok;
        ok = 1'b0;
        bus.s_valid   = 1'b1;
        bus.s_pix_ch0 = pix_t'(p0);
        bus.s_pix_ch1 = pix_t'(p1);
        bus.s_coef    = coef_t'(c);
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        check("beat_accept", longint'(ok), 1);
    endtask

    task automatic group(input int c[4], input int p0[4], input int p1[4]);
        for (int i = 0; i < 4; i++) drive(p0[i], p1[i], c[i]);
        bus.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     hc[4];
        int     hp0[4];
        int     hp1[4];
        int     sums0;
        longint t0;

        hc  = '{-16, 144, 144, -16};
        hp0 = '{100, 100, 100, 100};
        hp1 = '{0, 255, 255, 0};

        aresetn       = 1'b0;
        sclr          = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_pix_ch0 = '0;
        bus.s_pix_ch1 = '0;
        bus.s_coef    = '0;
        bus.m_ready   = 1'b1;

        #12;
        check("rst_m_valid", longint'(bus.m_valid), 0);
        check("rst_acc0", longint'(bus.m_acc_ch0), 0);
        check("rst_acc1", longint'(bus.m_acc_ch1), 0);
        check("rst_tap_idx", longint'(bus.tap_idx), 0);
        check("rst_s_ready", longint'(bus.s_ready), 1);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;

        // Half-phase kernel; result visible the cycle after the 4th beat
        group(hc, hp0, hp1);
        check("half_valid", longint'(bus.m_valid), 1);
        check("half_ch0", longint'(bus.m_acc_ch0), 25600);
        check("half_ch1", longint'(bus.m_acc_ch1), 73440);
        idle(2);

        // Most negative coefficient on every tap
        group('{-512, -512, -512, -512}, '{255, 255, 255, 255}, '{0, 0, 0, 0});
        check("neg_ch0", longint'(bus.m_acc_ch0), -522240);
        check("neg_ch1", longint'(bus.m_acc_ch1), 0);
        idle(2);

        // Backpressure: first sum held, next group stalls only on its last tap
        bus.m_ready = 1'b0;
        group(hc, hp0, hp1);
        check("bp_first_ch0", longint'(bus.m_acc_ch0), 25600);
        drive(1, 9, 0);
        drive(7, 8, 256);
        drive(3, 7, 0);
        bus.s_pix_ch0 = pix_t'(4);
        bus.s_pix_ch1 = pix_t'(6);
        bus.s_coef    = coef_t'(0);
        repeat (3) begin
            @(negedge clk);
            check("bp_s_ready", longint'(bus.s_ready), 0);
            check("bp_tap_idx", longint'(bus.tap_idx), 3);
            check("bp_hold_ch0", longint'(bus.m_acc_ch0), 25600);
            check("bp_hold_ch1", longint'(bus.m_acc_ch1), 73440);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check("bp_second_valid", longint'(bus.m_valid), 1);
        check("bp_second_ch0", longint'(bus.m_acc_ch0), 1792);
        check("bp_second_ch1", longint'(bus.m_acc_ch1), 2048);
        idle(2);

        // Back-to-back streaming: 8 groups in 32 cycles
        sums0 = n_sums;
        t0    = longint'($time);
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 4; i++) begin
                drive(int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(1023)) - 512);
            end
        end
        check("stream_cycles", (longint'($time) - t0) / 10, 32);
        idle(3);
        check("stream_sums", longint'(n_sums - sums0), 8);

        // Mid-group sclr while a sum is held; the beat on the sclr cycle is dropped
        bus.m_ready = 1'b0;
        group(hc, hp0, hp1);
        drive(255, 0, -512);
        drive(255, 0, -512);
        drive(255, 0, -512);
        sclr          = 1'b1;
        bus.s_valid   = 1'b1;
        bus.s_pix_ch0 = pix_t'(200);
        bus.s_pix_ch1 = pix_t'(50);
        bus.s_coef    = coef_t'(100);
        @(posedge clk); #1;
        sclr        = 1'b0;
        bus.s_valid = 1'b0;
        check("sclr_m_valid", longint'(bus.m_valid), 0);
        check("sclr_tap_idx", longint'(bus.tap_idx), 0);
        check("sclr_acc0", longint'(bus.m_acc_ch0), 0);
        check("sclr_acc1", longint'(bus.m_acc_ch1), 0);
        bus.m_ready = 1'b1;
        group('{64, 64, 64, 64}, '{1, 2, 3, 4}, '{10, 20, 30, 40});
        check("sclr_next_ch0", longint'(bus.m_acc_ch0), 640);
        check("sclr_next_ch1", longint'(bus.m_acc_ch1), 6400);
        idle(2);

        // Async reset pulse between edges, mid-group
        drive(100, 0, -16);
        drive(100, 255, 144);
        #2;
        bus.s_valid = 1'b0;
        aresetn     = 1'b0;
        #1;
        check("arst_m_valid", longint'(bus.m_valid), 0);
        check("arst_tap_idx", longint'(bus.tap_idx), 0);
        check("arst_acc0", longint'(bus.m_acc_ch0), 0);
        check("arst_acc1", longint'(bus.m_acc_ch1), 0);
        check("arst_s_ready", longint'(bus.s_ready), 1);
        #3 aresetn = 1'b1;
        @(posedge clk); #1;
        group(hc, hp0, hp1);
        check("arst_next_ch0", longint'(bus.m_acc_ch0), 25600);
        check("arst_next_ch1", longint'(bus.m_acc_ch1), 73440);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
